// File: rtl/press_pattern_decoder.sv
// Classifies cleaned button presses as single or double presses with a timed
// second-press window, a post-double lockout, one-cycle event pulses and a wrapping event counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a first press
// ST_WAIT2   | first press seen, timing the second-press window
// ST_LOCKOUT | double press decoded, presses ignored until timer expires
module press_pattern_decoder #(
    parameter int WINDOW_CYCLES  = 1250000,
    parameter int LOCKOUT_CYCLES = 500000,
    parameter int TW             = 21
) (
    input  logic       clk5,
    input  logic       reset,
    input  logic       clean_in,
    output logic       single_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] event_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT2   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          r_clean_d;
    logic          r_single;
    logic          r_double;
    logic          r_busy;
    logic [7:0]    r_count;
    logic          w_press;
    logic          w_single_nxt;
    logic          w_double_nxt;

    assign w_press = clean_in & ~r_clean_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_single_nxt = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_nxt = ST_WAIT2;
                    w_timer_nxt = '0;
                end
            end
            ST_WAIT2: begin
                // A press on the final window cycle still counts as a double.
                if (w_press) begin
                    w_double_nxt = 1'b1;
                    w_state_nxt  = ST_LOCKOUT;
                    w_timer_nxt  = '0;
                end else if (r_timer == WIN_LAST) begin
                    w_single_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == LOCK_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_clean_d <= 1'b0;
            r_single  <= 1'b0;
            r_double  <= 1'b0;
            r_busy    <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_clean_d <= clean_in;
            r_single  <= w_single_nxt;
            r_double  <= w_double_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_single_nxt | w_double_nxt) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign single_press = r_single;
    assign double_press = r_double;
    assign busy         = r_busy;
    assign event_count  = r_count;

endmodule

// File: tb/tb_press_pattern_decoder.sv
// Scoreboard bench for press_pattern_decoder: a deadline-based reference model
// queues the expected outputs per clock edge, a monitor pops and compares them.
module tb_press_pattern_decoder;

    localparam int W = 10;
    localparam int L = 6;

    logic       clk5 = 1'b0;
    logic       reset;
    logic       clean_in;
    logic       single_press;
    logic       double_press;
    logic       busy;
    logic [7:0] event_count;

    always #5 clk5 = ~clk5;

    press_pattern_decoder #(
        .WINDOW_CYCLES (W),
        .LOCKOUT_CYCLES(L),
        .TW            (5)
    ) dut (
        .clk5        (clk5),
        .reset       (reset),
        .clean_in    (clean_in),
        .single_press(single_press),
        .double_press(double_press),
        .busy        (busy),
        .event_count (event_count)
    );

    typedef struct packed {
        logic       sp;
        logic       dp;
        logic       bsy;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model: press times and deadlines, not states.
    bit m_pending    = 1'b0;
    bit m_prev       = 1'b0;
    int m_first      = 0;
    int m_lock_until = -100;
    int m_count      = 0;

    function void model_edge(int e, logic v, logic r);
        exp_t x;
        bit   press;
        x = '0;
        if (r) begin
            m_pending    = 1'b0;
            m_prev       = 1'b0;
            m_lock_until = -100;
            m_count      = 0;
        end else begin
            press  = v && !m_prev;
            m_prev = v;
            if (e <= m_lock_until) begin
                // presses inside the lockout are discarded
            end else if (m_pending) begin
                if (press) begin
                    x.dp         = 1'b1;
                    m_pending    = 1'b0;
                    m_lock_until = e + L;
                end else if (e == m_first + W) begin
                    x.sp      = 1'b1;
                    m_pending = 1'b0;
                end
            end else if (press) begin
                m_pending = 1'b1;
                m_first   = e;
            end
            if (x.sp || x.dp) m_count = (m_count + 1) % 256;
            x.bsy = m_pending || (m_lock_until > e);
        end
        x.cnt = 8'(m_count);
        exp_q.push_back(x);
    endfunction

    task automatic check_reset_now(string tag);
        n_cmp++;
        if ({single_press, double_press, busy, event_count} !== 11'd0) begin
            n_bad++;
            $display("FAIL %s: outputs sp=%b dp=%b busy=%b cnt=%0d, required all zero",
                     tag, single_press, double_press, busy, event_count);
        end
    endtask

    task automatic step(logic v, logic r);
        @(negedge clk5);
        clean_in = v;
        reset    = r;
        model_edge(cyc + 1, v, r);
        if (r) begin
            #1;
            check_reset_now("reset_async");
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    // Monitor: outputs after edge cyc are checked 1 time unit past the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk5);
            #1;
            cyc++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow at edge %0d: no expected entry", cyc);
            end else begin
                e = exp_q.pop_front();
                if ({single_press, double_press, busy, event_count} !== e) begin
                    n_bad++;
                    $display("FAIL edge%0d: got sp=%b dp=%b busy=%b cnt=%0d, expected sp=%b dp=%b busy=%b cnt=%0d",
                             cyc, single_press, double_press, busy, event_count,
                             e.sp, e.dp, e.bsy, e.cnt);
                end
            end
        end
    end

    initial begin
        clean_in = 1'b0;
        reset    = 1'b1;
        model_edge(1, 1'b0, 1'b1);
        #1;
        check_reset_now("reset_init");
        step(0, 1);
        step(0, 1);
        idle(3);

        // single press
        step(1, 0);
        idle(15);

        // second press on the last window edge
        step(1, 0);
        idle(W - 1);
        step(1, 0);
        idle(12);

        // second press one edge past the window
        step(1, 0);
        idle(W);
        step(1, 0);
        idle(15);

        // lockout: presses every other cycle, then one on the first IDLE cycle
        step(1, 0);
        step(0, 0);
        step(1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            step(0, 0);
        end
        step(1, 0);
        idle(15);

        // held input counts once
        for (int i = 0; i < 5; i++) step(1, 0);
        idle(15);

        // reset during WAIT2 (high at E_4)
        step(1, 0);
        idle(3);
        step(0, 1);
        step(0, 1);
        idle(15);

        // counter wrap: 256 singles from zero
        for (int i = 0; i < 256; i++) begin
            step(1, 0);
            idle(W + 1);
        end

        // randomized pulse pairs around the window boundary
        for (int i = 0; i < 80; i++) begin
            step(1, 0);
            idle($urandom_range(W - 3, W + 2));
            step(1, 0);
            idle($urandom_range(0, L + 4));
            if ($urandom_range(0, 3) == 0) step(1, 0);
            idle($urandom_range(0, 3));
        end

        // random level noise with occasional resets
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 99) < 30), ($urandom_range(0, 399) == 0));
        end
        idle(W + L + 5);

        @(posedge clk5);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
